// File: rtl/pipe_buf_stage_if.sv
// Handshake bundle for one elastic pipeline buffer stage.
// The master side is the surrounding pipeline (upstream producer plus
// downstream consumer); the slave side is the buffer itself.
interface pipe_buf_stage_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 1
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;

   modport master (
      output flush, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count, full, empty
   );

   modport slave (
      input  flush, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count, full, empty
   );
endinterface

// File: rtl/pipe_buf_stage.sv
// Elastic pipeline buffer stage: DEPTH-entry circular buffer carrying an
// opaque packed payload with valid/ready handshaking, synchronous flush for
// branch squash and optional zeroing of the head payload on bubbles.
module pipe_buf_stage #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEPTH       = 1,
   parameter bit          PASS_READY  = 1'b1,
   parameter bit          BUBBLE_ZERO = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   pipe_buf_stage_if.slave bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Storage rounded up to 2**PW so a full-width pointer always indexes it;
   // slots at DEPTH and above are never written and stay zero.
   localparam int unsigned MN = 1 << PW;

   logic [WIDTH-1:0] mem [MN];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    cnt;
   logic             push;
   logic             pop;
   logic             is_full;
   logic             is_empty;

   // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign is_full  = (cnt == CW'(DEPTH));
   assign is_empty = (cnt == '0);
   assign push     = bus.in_valid & bus.in_ready;
   assign pop      = ~is_empty & bus.out_ready;

   // Acceptance: optionally let a same-cycle pop free the slot of a full buffer.
   always_comb begin
      bus.in_ready = ~is_full;
      if (PASS_READY) begin
         bus.in_ready = ~is_full | bus.out_ready;
      end
   end

   // Payload storage: written on an accepted push; a squashed push is dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < MN; i++) begin
            mem[i] <= '0;
         end
      end else if (push && !bus.flush) begin
         mem[wr_ptr] <= bus.in_data;
      end
   end

   // Pointer and occupancy update; flush overrides any push or pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (bus.flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Head presentation, with bubbles optionally reading as all-zero.
   always_comb begin
      bus.out_data = mem[rd_ptr];
      if (BUBBLE_ZERO && is_empty) begin
         bus.out_data = '0;
      end
   end

   assign bus.out_valid = ~is_empty;
   assign bus.count     = cnt;
   assign bus.full      = is_full;
   assign bus.empty     = is_empty;

   // Occupancy invariants.
   assert property (@(posedge clk) disable iff (!reset) !(is_full && is_empty));
   assert property (@(posedge clk) disable iff (!reset) cnt <= CW'(DEPTH));
endmodule

// File: doc/pipe_buf_stage.md
Name: pipe_buf_stage

Overview:
- Generic, parametrised pipeline buffer register for the RISC-V core. It replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one elastic stage.
- Each instance carries an arbitrary packed payload (one stage's struct) through a DEPTH-entry circular buffer. The buffer has valid/ready handshaking, synchronous flush for branch/jump squash, and optional zeroing of bubbles so downstream control bits read inactive.

Parameters:
- WIDTH, 32: payload width in bits; instantiated with $bits of the stage struct.
- DEPTH, 1: number of buffer entries, 1..8; need not be a power of two.
- PASS_READY, 1: 1 = in_ready may assert when full if out_ready is high (combinational out_ready->in_ready path); 0 = in_ready depends on registered state only.
- BUBBLE_ZERO, 1: 1 = out_data forced to all-zero whenever out_valid=0; 0 = out_data shows the entry at rd_ptr regardless of valid.

Ports:
- clk, input, 1: core clock; all state updates on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous squash of all buffered entries.
- in_valid, input, 1: upstream has a payload.
- in_data, input, WIDTH: upstream payload.
- in_ready, output, 1: stage accepts a payload this cycle.
- out_valid, output, 1: head entry is valid.
- out_data, output, WIDTH: head payload.
- out_ready, input, 1: downstream consumes head this cycle; low = stall.
- count, output, $clog2(DEPTH+1): number of occupied entries.
- full, output, 1: count==DEPTH.
- empty, output, 1: count==0.

Behaviour:
- Definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- Reset (reset=0, asynchronous): count=0, rd_ptr=0, wr_ptr=0, all storage entries=0. Outputs during reset: out_valid=0, empty=1, full=0, out_data=0, in_ready=1.
- Storage: on push, mem[wr_ptr]<=in_data and wr_ptr advances. On pop, rd_ptr advances.
- Pointer wrap: a pointer equal to DEPTH-1 goes to 0; no power-of-two arithmetic.
- Count update: push&!pop gives count+1; pop&!push gives count-1; push&pop leaves count unchanged (both pointers advance).
- Latency: one cycle. A payload pushed in cycle N appears on out_data with out_valid=1 in cycle N+1. There is no same-cycle bypass, even when empty.
- out_valid = (count!=0). out_data = mem[rd_ptr], or 0 when BUBBLE_ZERO=1 and out_valid=0.
- in_ready:
  - PASS_READY=1: (count<DEPTH) | out_ready.
  - PASS_READY=0: (count<DEPTH).
- Full with PASS_READY=1, in_valid=1 and out_ready=1: push and pop occur together, count stays DEPTH, no data lost.
- Stall (out_ready=0): head payload and out_valid held stable until popped; in_data is accepted only while not full.
- Flush (synchronous, highest priority):
  - Next state is count=0, rd_ptr=wr_ptr=0.
  - Any push or pop in the same cycle is discarded; pop has no effect on storage contents.
  - Storage contents are not cleared; with BUBBLE_ZERO=1 the output still reads 0.
  - in_ready is unaffected by flush (formula above).
- Flush while reset is asserted has no effect. Reset released mid-operation restarts from the empty state.
- count never exceeds DEPTH and never underflows. A push when not in_ready is impossible by construction.
- Verification checks these as assertions: full & empty never both 1, and count<=DEPTH.

Test Plan:
1. DEPTH=1, PASS_READY=1, BUBBLE_ZERO=1, out_ready=1 held; push 0xA5A5_0001..0004 on consecutive cycles -> out_data shows each one cycle later, out_valid=1 cycles 1..4, in_ready=1 throughout, count=1 steady.
2. DEPTH=3, out_ready=0; push 0x11, 0x22, 0x33, 0x44 -> full=1 after 3 pushes, in_ready=0 with 0x44 held upstream. Raising out_ready pops 0x11 and accepts 0x44 that same cycle (count stays 3). Drain order 0x22, 0x33, 0x44.
3. DEPTH=3, 7 push/pop pairs interleaved with single pushes -> pointers wrap 2->0, output order equals input order, count tracks exactly.
4. DEPTH=2, two entries held, assert flush with in_valid=1 (0x99) -> next cycle count=0, out_valid=0, out_data=0 (BUBBLE_ZERO=1), 0x99 not stored.
5. BUBBLE_ZERO=0, after draining a stage that held 0xDEAD_BEEF -> out_valid=0, out_data=0xDEAD_BEEF.
6. Assert reset asynchronously mid-cycle with count=2 -> count=0, out_valid=0, out_data=0 immediately, without a clock edge. After release, a push of 0x5 appears one cycle later.
